// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to sequential imem word writes; holds the CPU until a frame completes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 1000
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int          IDLE_W  = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WR,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE, S_ERR
  } state_e;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_END = S_CSUM;
`else
  localparam state_e S_END = S_DONE;
`endif

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W:0]     wcnt_q, wcnt_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                xfer;
  logic                counting;
  logic [15:0]         new_len;
  logic [ADDR_W:0]     wcnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  assign byte_ready_o = (state_q != S_WR);
  assign xfer         = byte_valid_i & byte_ready_o;
  assign imem_we_o    = (state_q == S_WR);
  assign imem_addr_o  = wcnt_q[ADDR_W-1:0];
  assign imem_wdata_o = wdata_q;
  assign cpu_hold_o   = (state_q != S_DONE);
  assign done_o       = (state_q == S_DONE);
  assign error_o      = (state_q == S_ERR);
  assign new_len      = {byte_data_i, len_q[7:0]};
  assign wcnt_inc     = wcnt_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    wdata_d = wdata_q;
    idle_d  = idle_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    counting = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
    counting = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
`endif

    // Idle watchdog first; a transfer in the case below overrides it.
    if (counting && !xfer) begin
      if (idle_q == IDLE_W'(TIMEOUT - 1)) state_d = S_ERR;
      else                                idle_d  = idle_q + IDLE_W'(1);
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (xfer && byte_data_i == SYNC_BYTE) begin
          state_d = S_LEN0;
          wcnt_d  = '0;
          bcnt_d  = '0;
          idle_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = byte_data_i;
          idle_d     = '0;
          state_d    = S_LEN1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ byte_data_i;
`endif
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d[15:8] = byte_data_i;
          idle_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d      = csum_q ^ byte_data_i;
`endif
          if (new_len == 16'd0)                state_d = S_END;
          else if ({1'b0, new_len} > MAX_LEN)  state_d = S_ERR;
          else                                 state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          wdata_d[{bcnt_q, 3'b000} +: 8] = byte_data_i;
          bcnt_d = bcnt_q + 2'd1;
          idle_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_data_i;
`endif
          if (bcnt_q == 2'd3) state_d = S_WR;
        end
      end
      S_WR: begin
        wcnt_d = wcnt_inc;
        idle_d = '0;
        if (17'(wcnt_inc) == {1'b0, len_q}) state_d = S_END;
        else                                state_d = S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          idle_d  = '0;
          state_d = (byte_data_i == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      wdata_q <= '0;
      idle_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      wdata_q <= wdata_d;
      idle_q  <= idle_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed and randomized frames checked against a frame-level reference model.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int TO     = 24;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_ni(reset_n), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
    .byte_ready_o(byte_ready), .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .cpu_hold_o(cpu_hold), .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] dut_mem [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  int          we_cnt, rdy_low, acc_cnt, last_addr;
  logic [7:0]  frame_q [$];
  int          exp_writes;
  logic        exp_done, exp_err;

  always @(posedge clk) begin
    if (imem_we) begin
      dut_mem[imem_addr] = imem_wdata;
      last_addr = int'(imem_addr);
      we_cnt++;
    end
    if (!byte_ready) rdy_low++;
    if (byte_valid && byte_ready) acc_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) chk("ready_wait", 32'(byte_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic append_csum(input logic corrupt);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 1; i < frame_q.size(); i++) cs ^= frame_q[i];
    frame_q.push_back(cs ^ {7'd0, corrupt});
`else
    if (corrupt) frame_q.push_back(8'h00);
`endif
  endtask

  task automatic build_frame(input int len, input logic corrupt);
    frame_q = {};
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(len));
    frame_q.push_back(8'(len >> 8));
    for (int i = 0; i < 4 * len; i++) frame_q.push_back(8'($urandom));
    append_csum(corrupt);
  endtask

  // Reference: interprets a whole frame and predicts the words written and the final status.
  task automatic model_frame();
    int len;
    logic [7:0] cs;
    len = int'(frame_q[1]) | (int'(frame_q[2]) << 8);
    exp_writes = 0; exp_done = 1'b0; exp_err = 1'b0;
    if (len > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < len; w++) begin
      exp_mem[w] = {frame_q[3+4*w+3], frame_q[3+4*w+2], frame_q[3+4*w+1], frame_q[3+4*w]};
      exp_writes++;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    cs = 8'h00;
    for (int i = 1; i < 3 + 4 * len; i++) cs ^= frame_q[i];
    if (frame_q[3 + 4 * len] == cs) exp_done = 1'b1;
    else                            exp_err  = 1'b1;
`else
    cs = 8'h00;
    exp_done = (cs == 8'h00);
`endif
  endtask

  task automatic run_frame(input int gap_max);
    for (int i = 0; i < DEPTH; i++) dut_mem[i] = 32'hDEADBEEF;
    we_cnt = 0; rdy_low = 0; acc_cnt = 0; last_addr = -1;
    foreach (frame_q[i]) begin
      repeat ($urandom_range(gap_max, 0)) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
      send_byte(frame_q[i]);
    end
    byte_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    int miss;
    model_frame();
    miss = 0;
    for (int w = 0; w < exp_writes; w++) if (dut_mem[w] !== exp_mem[w]) miss++;
    chk({tag, "_we"}, 32'(we_cnt), 32'(exp_writes));
    chk({tag, "_mem"}, 32'(miss), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_err"}, 32'(error), 32'(exp_err));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"}, 32'(byte_ready), 32'd1);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(error), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    we_cnt = 0; rdy_low = 0; acc_cnt = 0; last_addr = -1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Noise in IDLE
    frame_q = {8'h00, 8'hFF, 8'h5A};
    run_frame(0);
    chk("noise_we", 32'(we_cnt), 32'd0);
    chk("noise_hold", 32'(cpu_hold), 32'd1);
    chk("noise_done", 32'(done), 32'd0);

    // Reference program frame
    frame_q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h80, 8'hE2};
    append_csum(1'b0);
    run_frame(2);
    check_frame("ex");
    chk("ex_w0", dut_mem[0], 32'hE3A00013);
    chk("ex_w1", dut_mem[1], 32'hE2801001);

    // Back-to-back 3-word frame: ready drops only during the write cycles
    build_frame(3, 1'b0);
    run_frame(0);
    check_frame("b2b");
    chk("b2b_rdylow", 32'(rdy_low), 32'd3);
    chk("b2b_acc", 32'(acc_cnt), 32'(frame_q.size()));

    // Oversize length
    frame_q = {8'hA5, 8'h01, 8'h04};
    run_frame(0);
    check_frame("len1025");

    // Maximum length
    build_frame(DEPTH, 1'b0);
    run_frame(0);
    check_frame("len1024");
    chk("len1024_last", 32'(last_addr), 32'(DEPTH - 1));

    // Idle gap inside DATA
    we_cnt = 0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
    byte_valid = 1'b0;
    repeat (TO - 1) @(negedge clk);
    chk("gap_before", 32'(error), 32'd0);
    @(negedge clk);
    chk("gap_at", 32'(error), 32'd1);
    chk("gap_we", 32'(we_cnt), 32'd0);
    chk("gap_hold", 32'(cpu_hold), 32'd1);
    frame_q = {8'hA5, 8'h00, 8'h00};
    append_csum(1'b0);
    run_frame(0);
    check_frame("empty");

`ifdef IMEM_LOADER_CHECKSUM_EN
    build_frame(2, 1'b1);
    run_frame(1);
    check_frame("badcs");
`endif

    // Async reset in the middle of DATA
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
    byte_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    build_frame(2, 1'b0);
    run_frame(1);
    check_frame("postrst");

    // Randomized frames with leading noise and random gaps
    for (int f = 0; f < 8; f++) begin
      logic [7:0] nb;
      repeat ($urandom_range(2, 0)) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h3C;
        send_byte(nb);
      end
      build_frame(int'($urandom_range(6, 1)), 1'($urandom_range(3, 0) == 0));
      run_frame(3);
      check_frame($sformatf("rnd%0d", f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

endmodule
